// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-masked single-cycle writes, reads returned RD_LAT cycles after acceptance.
// Optional feature macro DMEM_ALIGN_CHECK_EN: drop misaligned accesses and flag them on err.
module data_mem_resp #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_mem_read,
    input  logic [3:0]  data_mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        err
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic              wr_req;
    logic              any_req;
    logic              misaligned;
    logic              wr_go;
    logic              rd_go;
    logic              unused_addr;

    assign idx     = data_addr[ADDR_W+1:2];
    assign wr_req  = |data_mem_write;
    assign any_req = wr_req | data_mem_read;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |data_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif
    // upper address bits alias onto the RAM and are deliberately dropped
    assign unused_addr = ^{data_addr[31:ADDR_W+2], data_addr[1:0]};

    assign wr_go = (state == IDLE) && wr_req && !misaligned;
    assign rd_go = (state == IDLE) && data_mem_read && !wr_req && !misaligned;
    assign busy  = (state == WAIT);

    // RAM contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < 4; i++) begin
                if (data_mem_write[i]) begin
                    mem[idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_idx     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && (misaligned || (wr_req && data_mem_read))) begin
                        err <= 1'b1;
                    end
                    if (rd_go) begin
                        rd_idx <= idx;
                        if (RD_LAT == 1) begin
                            data_out   <= mem[idx];
                            data_valid <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // requests during a read in flight are dropped, not queued
                    if (any_req) begin
                        err <= 1'b1;
                    end
                    if (cnt == 3'd1) begin
                        data_out   <= mem[rd_idx];
                        data_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (RD_LAT 2,3,4) share stimulus and are checked against a timestamp model.
module tb_data_mem_resp;
    localparam int N = 3;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout  [N];
    logic        dval  [N];
    logic        dbusy [N];
    logic        derr  [N];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_resp #(.ADDR_W(10), .RD_LAT(g + 2)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .data_mem_read(rd), .data_mem_write(wr),
            .data_addr(addr), .data_in(din),
            .data_out(dout[g]), .data_valid(dval[g]),
            .busy(dbusy[g]), .err(derr[g])
        );
    end

    // model: per-instance memory image plus a pending read with an absolute due edge
    logic [31:0] mm [N][1024];
    bit          kn [N][1024];
    bit          pend [N];
    int          due  [N];
    logic [31:0] pd   [N];
    bit          pk   [N];
    bit          ev   [N];
    logic [31:0] eo   [N];
    bit          ek   [N];
    bit          ee   [N];
    int          cyc = 0;
    int          w;
    bit          wasb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pend[i] = 0; ev[i] = 0; eo[i] = '0; ek[i] = 1; ee[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                ev[i] = 0;
                wasb = pend[i];
                if (pend[i] && cyc == due[i]) begin
                    ev[i] = 1; eo[i] = pd[i]; ek[i] = pk[i]; pend[i] = 0;
                end
                if (rd || wr != 4'h0) begin
                    w = int'(addr[11:2]);
                    if (wasb) ee[i] = 1;
                    else if (ALIGN && addr[1:0] != 2'b00) ee[i] = 1;
                    else if (wr != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (wr[b]) mm[i][w][8*b +: 8] = din[8*b +: 8];
                        if (wr == 4'hF) kn[i][w] = 1;
                        if (rd) ee[i] = 1;
                    end else begin
                        pd[i] = mm[i][w]; pk[i] = kn[i][w];
                        pend[i] = 1; due[i] = cyc + (i + 2) - 1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("inst%0d valid", i), 32'(dval[i]), 32'(ev[i]));
                check($sformatf("inst%0d busy", i), 32'(dbusy[i]), 32'(pend[i]));
                check($sformatf("inst%0d err", i), 32'(derr[i]), 32'(ee[i]));
                if (ek[i]) check($sformatf("inst%0d data_out", i), dout[i], eo[i]);
            end
        end
    end

    task automatic req(input logic r, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = r; wr = s; addr = a; din = d;
        @(negedge clk);
        rd = 1'b0; wr = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        rd = 1'b0; wr = 4'h0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("reset data_out", dout[i], 32'h0);
            check("reset valid", 32'(dval[i]), 32'h0);
            check("reset busy", 32'(dbusy[i]), 32'h0);
            check("reset err", 32'(derr[i]), 32'h0);
        end

        // full-word write then read, RD_LAT=2 timing on instance 0
        req(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        req(1'b1, 4'h0, 32'h10, 32'h0);
        check("t1 busy cycle1", 32'(dbusy[0]), 32'h1);
        check("t1 no early valid", 32'(dval[0]), 32'h0);
        @(negedge clk);
        check("t1 valid", 32'(dval[0]), 32'h1);
        check("t1 data", dout[0], 32'hDEADBEEF);
        check("t1 busy low", 32'(dbusy[0]), 32'h0);
        @(negedge clk);
        check("t1 single pulse", 32'(dval[0]), 32'h0);
        idle(6);

        // byte-lane merge
        req(1'b0, 4'hF, 32'h20, 32'h11223344);
        req(1'b0, 4'b0101, 32'h20, 32'hAABBCCDD);
        req(1'b1, 4'h0, 32'h20, 32'h0);
        idle(6);
        for (int i = 0; i < N; i++) check("t2 merged", dout[i], 32'h11BB33DD);

        // misaligned write
        req(1'b0, 4'hF, 32'h30, 32'h55667788);
        req(1'b0, 4'b0001, 32'h31, 32'h000000EE);
        req(1'b1, 4'h0, 32'h30, 32'h0);
        idle(6);
        for (int i = 0; i < N; i++) begin
            check("t3 align data", dout[i], ALIGN ? 32'h55667788 : 32'h556677EE);
            check("t3 align err", 32'(derr[i]), ALIGN ? 32'h1 : 32'h0);
        end

        // read and write together: write wins, read dropped
        req(1'b1, 4'b0001, 32'h30, 32'h00000099);
        idle(4);
        for (int i = 0; i < N; i++) check("t4 rw err", 32'(derr[i]), 32'h1);
        req(1'b1, 4'h0, 32'h30, 32'h0);
        idle(6);
        for (int i = 0; i < N; i++) check("t4 rw data", dout[i], 32'h55667799);

        // request while busy
        do_reset();
        for (int i = 0; i < N; i++) check("t5 err cleared", 32'(derr[i]), 32'h0);
        @(negedge clk); rd = 1'b1; addr = 32'h10;
        @(negedge clk);
        @(negedge clk); rd = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dval[1]) pulses++;
        end
        check("t5 one pulse", 32'(pulses), 32'h1);
        check("t5 data", dout[1], 32'hDEADBEEF);
        check("t5 err sticky", 32'(derr[1]), 32'h1);

        // reset in the second cycle of an RD_LAT=4 read
        do_reset();
        req(1'b1, 4'h0, 32'h20, 32'h0);
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dval[2]) pulses++;
        end
        check("t6 no pulse", 32'(pulses), 32'h0);
        check("t6 data reset", dout[2], 32'h0);
        check("t6 busy reset", 32'(dbusy[2]), 32'h0);
        check("t6 err reset", 32'(derr[2]), 32'h0);
        req(1'b1, 4'h0, 32'h20, 32'h0);
        idle(6);
        check("t6 read after reset", dout[2], 32'h11BB33DD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
